clock_mode_controller: RTL and testbench

//  Central sequencer for the alarm clock. Routes 1 Hz carries to the time counters in RUN,

---
 rtl/clock_pkg.sv | 24 ++
 rtl/clock_mode_controller_edge_rise.sv | 29 ++
 rtl/clock_mode_controller.sv | 168 ++++++++++++++++
 tb/tb_clock_mode_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// Module   : clock_pkg
// Brief    : Mode encodings and counter width helper for the alarm clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10,
    MODE_RING      = 2'b11
  } mode_e;

  // Bits needed to hold values 0..modulus-1 (never less than one bit).
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_mode_controller_edge_rise.sv
// ============================================================================
// Module   : edge_rise
// Brief    : One-bit rising-edge detector with asynchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= d;
    end
  end

  assign rise = d & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/clock_mode_controller.sv
// ============================================================================
// Module   : clock_mode_controller
// Brief    : Alarm-clock sequencer: carry routing, SET-mode button strobes, alarm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_mode_controller
  import clock_pkg::*;
#(
  parameter int N_MIN         = 60,
  parameter int N_HR          = 24,
  parameter int SET_TIMEOUT_S = 30,
  parameter int RING_MAX_MIN  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_1s,
  input  logic                         sec_carry,
  input  logic                         min_carry,
  input  logic                         btn_mode,
  input  logic                         btn_sel,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_stop,
  input  logic                         alarm_on,
  input  logic [cnt_width(N_MIN)-1:0]  cur_min,
  input  logic [cnt_width(N_HR)-1:0]   cur_hr,
  input  logic [cnt_width(N_MIN)-1:0]  alm_min,
  input  logic [cnt_width(N_HR)-1:0]   alm_hr,
  output logic                         sec_en,
  output logic                         sec_clr,
  output logic                         tmin_en,
  output logic                         tmin_ud,
  output logic                         thr_en,
  output logic                         thr_ud,
  output logic                         amin_en,
  output logic                         amin_ud,
  output logic                         ahr_en,
  output logic                         ahr_ud,
  output logic [1:0]                   mode,
  output logic                         field_sel,
  output logic                         ringing,
  output logic                         blink
);

  localparam int IW = cnt_width(SET_TIMEOUT_S + 1);
  localparam int RW = cnt_width(RING_MAX_MIN + 1);
  localparam logic [IW-1:0] c_idle_last = IW'(SET_TIMEOUT_S - 1);
  localparam logic [RW-1:0] c_ring_last = RW'(RING_MAX_MIN - 1);

  mode_e         r_state, w_state_nxt;
  logic          r_field, w_field_nxt;
  logic [IW-1:0] r_idle, w_idle_nxt;
  logic [RW-1:0] r_ring_cnt, w_ring_nxt;
  logic          r_blink, w_blink_nxt;
  logic          r_ringing, w_ringing_nxt;
  logic [9:0]    r_strb, w_strb;

  logic w_sec_rise, w_min_rise, w_match_rise, w_match, w_any_btn, w_adjust;

  assign w_match   = alarm_on & (cur_min == alm_min) & (cur_hr == alm_hr);
  assign w_any_btn = btn_mode | btn_sel | btn_up | btn_down | btn_stop;
  assign w_adjust  = btn_up ^ btn_down;

  edge_rise u_sec_edge   (.clk(clk), .rst(rst), .d(sec_carry), .rise(w_sec_rise));
  edge_rise u_min_edge   (.clk(clk), .rst(rst), .d(min_carry), .rise(w_min_rise));
  edge_rise u_match_edge (.clk(clk), .rst(rst), .d(w_match),   .rise(w_match_rise));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= MODE_RUN;
      r_field    <= 1'b0;
      r_idle     <= '0;
      r_ring_cnt <= '0;
      r_blink    <= 1'b1;
      r_ringing  <= 1'b0;
      r_strb     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_field    <= w_field_nxt;
      r_idle     <= w_idle_nxt;
      r_ring_cnt <= w_ring_nxt;
      r_blink    <= w_blink_nxt;
      r_ringing  <= w_ringing_nxt;
      r_strb     <= w_strb;
    end
  end

  // Strobe vector bit order: sec_en sec_clr tmin_en tmin_ud thr_en thr_ud
  // amin_en amin_ud ahr_en ahr_ud.
  always_comb begin
    w_state_nxt = r_state;
    w_field_nxt = r_field;
    w_idle_nxt  = r_idle;
    w_ring_nxt  = r_ring_cnt;
    w_strb      = '0;
    case (r_state)
      MODE_RUN, MODE_RING: begin
        w_strb[9] = tick_1s;
        w_strb[7] = w_sec_rise;
        w_strb[6] = w_sec_rise;
        w_strb[5] = w_min_rise;
        w_strb[4] = w_min_rise;
        if (r_state == MODE_RUN) begin
          // Alarm takes priority over a coincident mode press.
          if (w_match_rise) begin
            w_state_nxt = MODE_RING;
            w_ring_nxt  = '0;
          end else if (btn_mode) begin
            w_state_nxt = MODE_SET_TIME;
            w_idle_nxt  = '0;
          end
        end else if (btn_stop | btn_mode | btn_up | btn_down | ~alarm_on) begin
          w_state_nxt = MODE_RUN;
        end else if (w_sec_rise) begin
          if (r_ring_cnt == c_ring_last) begin
            w_state_nxt = MODE_RUN;
          end else begin
            w_ring_nxt = r_ring_cnt + 1'b1;
          end
        end
      end
      default: begin
        if (w_adjust) begin
          if (r_state == MODE_SET_TIME) begin
            if (r_field) {w_strb[5], w_strb[4]} = {1'b1, btn_up};
            else         {w_strb[7], w_strb[6]} = {1'b1, btn_up};
          end else begin
            if (r_field) {w_strb[1], w_strb[0]} = {1'b1, btn_up};
            else         {w_strb[3], w_strb[2]} = {1'b1, btn_up};
          end
        end
        if (btn_sel) begin
          w_field_nxt = ~r_field;
        end
        if (w_any_btn) begin
          w_idle_nxt = '0;
        end else if (tick_1s) begin
          if (r_idle == c_idle_last) begin
            w_state_nxt = MODE_RUN;
          end else begin
            w_idle_nxt = r_idle + 1'b1;
          end
        end
        if (btn_mode) begin
          w_state_nxt = (r_state == MODE_SET_TIME) ? MODE_SET_ALARM : MODE_RUN;
        end
        w_strb[8] = (r_state == MODE_SET_TIME) && (w_state_nxt != MODE_SET_TIME);
      end
    endcase
    if (w_state_nxt != r_state) begin
      w_field_nxt = 1'b0;
    end
    w_blink_nxt   = (w_state_nxt == MODE_RUN) ? 1'b1 : (tick_1s ? ~r_blink : r_blink);
    w_ringing_nxt = (w_state_nxt == MODE_RING);
  end

  assign {sec_en, sec_clr, tmin_en, tmin_ud, thr_en, thr_ud,
          amin_en, amin_ud, ahr_en, ahr_ud} = r_strb;
  assign mode      = r_state;
  assign field_sel = r_field;
  assign ringing   = r_ringing;
  assign blink     = r_blink;

endmodule

`default_nettype wire

// File: tb/tb_clock_mode_controller.sv
// ============================================================================
// Module   : tb_clock_mode_controller
// Brief    : Self-checking bench with a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_mode_controller;

  localparam int SET_TIMEOUT = 30;
  localparam int RING_MAX    = 5;

  logic clk = 1'b0, rst = 1'b0;
  logic tick_1s = 1'b0, sec_carry = 1'b0, min_carry = 1'b0;
  logic btn_mode = 1'b0, btn_sel = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_stop = 1'b0;
  logic alarm_on = 1'b0;
  logic [5:0] cur_min = 6'd0, alm_min = 6'd0;
  logic [4:0] cur_hr = 5'd7, alm_hr = 5'd7;
  logic sec_en, sec_clr, tmin_en, tmin_ud, thr_en, thr_ud;
  logic amin_en, amin_ud, ahr_en, ahr_ud, field_sel, ringing, blink;
  logic [1:0] mode;
  logic [14:0] dut_v;

  int n_assert = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  clock_mode_controller dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .sec_carry(sec_carry), .min_carry(min_carry),
    .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_up(btn_up), .btn_down(btn_down),
    .btn_stop(btn_stop), .alarm_on(alarm_on), .cur_min(cur_min), .cur_hr(cur_hr),
    .alm_min(alm_min), .alm_hr(alm_hr), .sec_en(sec_en), .sec_clr(sec_clr),
    .tmin_en(tmin_en), .tmin_ud(tmin_ud), .thr_en(thr_en), .thr_ud(thr_ud),
    .amin_en(amin_en), .amin_ud(amin_ud), .ahr_en(ahr_en), .ahr_ud(ahr_ud),
    .mode(mode), .field_sel(field_sel), .ringing(ringing), .blink(blink)
  );

  assign dut_v = {sec_en, sec_clr, tmin_en, tmin_ud, thr_en, thr_ud,
                  amin_en, amin_ud, ahr_en, ahr_ud, mode, field_sel, ringing, blink};

  // Reference model: mode 0 RUN, 1 SET_TIME, 2 SET_ALARM, 3 RING.
  typedef struct {
    int          md;
    bit          field;
    int          idle;
    int          ring;
    bit          blink;
    bit          p_sec;
    bit          p_min;
    bit          p_match;
    logic [14:0] outv;
  } mstate_t;

  mstate_t ms;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.md = 0; s.field = 0; s.idle = 0; s.ring = 0; s.blink = 1;
    s.p_sec = 0; s.p_min = 0; s.p_match = 0;
    s.outv = 15'b000000000000001;
    return s;
  endfunction

  function automatic mstate_t model_step(input mstate_t s);
    mstate_t n = s;
    bit [9:0] st = '0;
    bit sr, mr, xr, mt, any_btn;
    int idx;
    mt = alarm_on && (cur_min == alm_min) && (cur_hr == alm_hr);
    sr = sec_carry && !s.p_sec;
    mr = min_carry && !s.p_min;
    xr = mt && !s.p_match;
    n.p_sec = sec_carry; n.p_min = min_carry; n.p_match = mt;
    any_btn = btn_mode || btn_sel || btn_up || btn_down || btn_stop;
    if (s.md == 0 || s.md == 3) begin
      st[9] = tick_1s;
      st[7] = sr; st[6] = sr;
      st[5] = mr; st[4] = mr;
      if (s.md == 0) begin
        if (xr) begin n.md = 3; n.ring = 0; end
        else if (btn_mode) begin n.md = 1; n.idle = 0; end
      end else begin
        if (btn_stop || btn_mode || btn_up || btn_down || !alarm_on) n.md = 0;
        else if (sr) begin
          n.ring = s.ring + 1;
          if (n.ring >= RING_MAX) n.md = 0;
        end
      end
    end else begin
      if (btn_up != btn_down) begin
        idx = ((s.md == 1) ? 7 : 3) - (s.field ? 2 : 0);
        st[idx] = 1'b1;
        st[idx-1] = btn_up;
      end
      if (btn_sel) n.field = !s.field;
      if (any_btn) n.idle = 0;
      else if (tick_1s) begin
        n.idle = s.idle + 1;
        if (n.idle >= SET_TIMEOUT) n.md = 0;
      end
      if (btn_mode) n.md = (s.md == 1) ? 2 : 0;
      if (s.md == 1 && n.md != 1) st[8] = 1'b1;
    end
    if (n.md != s.md) n.field = 0;
    n.blink = (n.md == 0) ? 1'b1 : (tick_1s ? !s.blink : s.blink);
    n.outv = {st, 2'(n.md), n.field, n.md == 3, n.blink};
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) ms <= model_reset();
    else     ms <= model_step(ms);
  end

  always @(negedge clk) begin
    if (checking) begin
      n_assert++;
      if (dut_v !== ms.outv) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t got=%b want=%b", $time, dut_v, ms.outv);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int bdiv;
    #1 rst = 1'b1;
    checking = 1'b1;
    repeat (2) next();
    chk("reset_mode", int'(mode), 0);
    chk("reset_blink", int'(blink), 1);
    chk("reset_ringing", int'(ringing), 0);
    chk("reset_strobes", int'(dut_v[14:5]), 0);
    rst = 1'b0;
    next();

    // 60 seconds in RUN, carry rising on the 60th tick
    cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      tick_1s = 1'b1;
      if (k == 60) sec_carry = 1'b1;
      next();
      tick_1s = 1'b0;
      cnt += int'(tmin_en);
      if (k == 60) begin
        chk("tmin_en_at_tick60", int'(tmin_en), 1);
        chk("tmin_ud_at_tick60", int'(tmin_ud), 1);
      end
      next();
      cnt += int'(tmin_en);
    end
    chk("tmin_en_count_60ticks", cnt, 1);
    sec_carry = 1'b0;

    // min_carry level held in RUN
    min_carry = 1'b1;
    cnt = 0;
    repeat (3) begin next(); cnt += int'(thr_en); end
    min_carry = 1'b0;
    next(); cnt += int'(thr_en);
    chk("thr_en_count_run", cnt, 1);

    btn_mode = 1'b1; next(); btn_mode = 1'b0;
    chk("mode_set_time", int'(mode), 1);

    min_carry = 1'b1;
    cnt = 0;
    repeat (3) begin next(); cnt += int'(thr_en); end
    min_carry = 1'b0;
    next(); cnt += int'(thr_en);
    chk("thr_en_count_set", cnt, 0);

    for (int k = 0; k < 3; k++) begin
      btn_up = 1'b1; next(); btn_up = 1'b0;
      chk("up_tmin_en", int'(tmin_en), 1);
      chk("up_tmin_ud", int'(tmin_ud), 1);
      next();
    end
    btn_sel = 1'b1; next(); btn_sel = 1'b0;
    chk("sel_field_hours", int'(field_sel), 1);
    btn_down = 1'b1; next(); btn_down = 1'b0;
    chk("down_thr_en", int'(thr_en), 1);
    chk("down_thr_ud", int'(thr_ud), 0);
    chk("down_mode", int'(mode), 1);

    btn_up = 1'b1; btn_down = 1'b1; next(); btn_up = 1'b0; btn_down = 1'b0;
    chk("updown_no_strobe", int'({tmin_en, thr_en, amin_en, ahr_en}), 0);

    btn_mode = 1'b1; next(); btn_mode = 1'b0;
    chk("mode_set_alarm", int'(mode), 2);
    chk("sec_clr_leave_set_time", int'(sec_clr), 1);
    next();

    // idle timeout from SET_ALARM
    cnt = 0;
    for (int k = 1; k <= SET_TIMEOUT; k++) begin
      tick_1s = 1'b1; next(); tick_1s = 1'b0;
      cnt += int'(sec_clr);
      if (k == SET_TIMEOUT - 1) chk("mode_before_timeout", int'(mode), 2);
      if (k == SET_TIMEOUT) chk("mode_after_timeout", int'(mode), 0);
      next();
      cnt += int'(sec_clr);
    end
    chk("no_sec_clr_alarm_timeout", cnt, 0);

    // alarm 07:00
    alarm_on = 1'b1; next();
    chk("ring_on_match", int'(ringing), 1);
    chk("mode_ring", int'(mode), 3);
    btn_stop = 1'b1; next(); btn_stop = 1'b0;
    chk("stop_silences", int'(ringing), 0);
    cnt = 0;
    repeat (4) begin next(); cnt += int'(ringing); end
    chk("no_rering_held_match", cnt, 0);
    cur_min = 6'd1; next(); cur_min = 6'd0; next();
    chk("rering_after_drop", int'(ringing), 1);
    for (int e = 1; e <= RING_MAX; e++) begin
      sec_carry = 1'b1; next();
      chk("ring_after_minute_edge", int'(ringing), (e < RING_MAX) ? 1 : 0);
      sec_carry = 1'b0; next();
    end

    cur_min = 6'd1; next(); cur_min = 6'd0; next();
    chk("ring_before_rst", int'(ringing), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ring_mode", int'(mode), 0);
    chk("rst_mid_ring_ringing", int'(ringing), 0);
    next(); next();
    rst = 1'b0;
    next();

    // randomized traffic, busy buttons then sparse buttons
    for (int i = 0; i < 3000; i++) begin
      bdiv = (i < 1500) ? 15 : 200;
      tick_1s  = ($urandom_range(0, (i < 1500) ? 5 : 1) == 0);
      btn_mode = ($urandom_range(0, bdiv) == 0);
      btn_sel  = ($urandom_range(0, bdiv) == 0);
      btn_up   = ($urandom_range(0, bdiv) == 0);
      btn_down = ($urandom_range(0, bdiv) == 0);
      btn_stop = ($urandom_range(0, bdiv) == 0);
      if ($urandom_range(0, 9) == 0) sec_carry = ~sec_carry;
      if ($urandom_range(0, 19) == 0) min_carry = ~min_carry;
      alarm_on = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 9) == 0)
        cur_min = ($urandom_range(0, 1) == 0) ? alm_min : 6'($urandom_range(0, 59));
      next();
    end
    {tick_1s, btn_mode, btn_sel, btn_up, btn_down, btn_stop} = '0;
    next();
    checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
